dmem_port_arbiter: RTL and testbench

//   Shares the single-port dmem syncram between two requesters: port 0 (processor) and port 1 (loader/debug DMA).

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_pick.sv | 47 ++++
 rtl/dmem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared definitions for the dmem port arbiter:
//     state_t  : FSM state encodings (ST_IDLE, ST_ISSUE, ST_WAIT)
//     PORT_CPU : index of the processor requester (port 0)
//     PORT_LD  : index of the loader/debug DMA requester (port 1)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
//   Combinational winner select between the two dmem requesters.
//   Build option: DMEM_ARB_RR_EN
//     defined     : round-robin, a tie goes to the port that did not win last
//     not defined : fixed priority, port 0 (processor) always wins a tie
// Ports
//   i_req0, i_req1 : pending requests
//   i_last         : port index of the most recent grant
//   o_any          : at least one request pending
//   o_winner       : port index to serve (meaningful only when o_any = 1)
// -----------------------------------------------------------------------------
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_any,
  output logic o_winner
);

  assign o_any = i_req0 | i_req1;

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    o_winner = PORT_CPU;
    if (i_req0 && i_req1) begin
      o_winner = ~i_last;
    end else if (i_req1) begin
      o_winner = PORT_LD;
    end
  end
`else
  // Fixed priority never looks at the grant history.
  logic w_unused_last;
  assign w_unused_last = i_last;

  always_comb begin
    o_winner = PORT_CPU;
    if (!i_req0 && i_req1) begin
      o_winner = PORT_LD;
    end
  end
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single-port dmem syncram between port 0 (processor) and
//   port 1 (loader/debug DMA). One access is in flight at a time.
//   Build option: DMEM_ARB_RR_EN selects round-robin instead of fixed priority
//   (handled inside dmem_arb_pick).
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
//   them until it sees gntN (one-cycle pulse, the cycle the access is driven
//   onto dmem). A read result returns as a one-cycle rvalidN pulse exactly
//   RD_LAT+1 cycles after gntN, qualifying the shared rdata bus. There is no
//   back-pressure on rvalid; the requester must take rdata that cycle.
//
// Ports
//   clock, reset          : dmem clock, synchronous active-high reset
//   req/we/addr/wdata 0,1 : request side of each port
//   gnt0/gnt1             : grant pulses
//   rvalid0/rvalid1, rdata: read return
//   address_dmem/data/wren: dmem drive, q_dmem: dmem read data
//   busy                  : FSM not in IDLE
//   dbg_state             : current FSM state
// -----------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_capture;

  logic              w_any;
  logic              w_winner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  logic              r_last;
  logic              r_winner;
  logic              r_we;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rdata;

  dmem_arb_pick u_pick (
    .i_req0   (req0),
    .i_req1   (req1),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  always_comb begin
    w_sel_we    = we0;
    w_sel_addr  = addr0;
    w_sel_wdata = wdata0;
    if (w_winner == PORT_LD) begin
      w_sel_we    = we1;
      w_sel_addr  = addr1;
      w_sel_wdata = wdata1;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; w_accept/w_capture are the one-cycle load strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next = ST_ISSUE;
          w_accept     = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_next = r_we ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // q_dmem is valid RD_LAT cycles after ISSUE, i.e. in the WAIT cycle
        // where the counter sits at RD_LAT-1; the counter never saturates.
        if (r_lat_cnt == LAT_LAST) begin
          w_state_next = ST_IDLE;
          w_capture    = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: dmem drive registers, grant/return pulses, latency counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last    <= PORT_LD;
      r_winner  <= PORT_CPU;
      r_we      <= 1'b0;
      r_lat_cnt <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_wren    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_rdata   <= '0;
    end else begin
      // Pulses default low; they are set only for the single cycle after
      // their load strobe.
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_wren    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;

      if (w_accept) begin
        r_winner <= w_winner;
        r_last   <= w_winner;
        r_we     <= w_sel_we;
        r_addr   <= w_sel_addr;
        r_data   <= w_sel_wdata;
        r_wren   <= w_sel_we;
        r_gnt0   <= (w_winner == PORT_CPU);
        r_gnt1   <= (w_winner == PORT_LD);
      end

      if (r_state == ST_ISSUE) begin
        r_lat_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end

      if (w_capture) begin
        r_rdata   <= q_dmem;
        r_rvalid0 <= (r_winner == PORT_CPU);
        r_rvalid1 <= (r_winner == PORT_LD);
      end
    end
  end

  assign gnt0         = r_gnt0;
  assign gnt1         = r_gnt1;
  assign rvalid0      = r_rvalid0;
  assign rvalid1      = r_rvalid1;
  assign rdata        = r_rdata;
  assign address_dmem = r_addr;
  assign data         = r_data;
  assign wren         = r_wren;
  assign busy         = (r_state != ST_IDLE);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, wren, busy;
  logic [DATA_W-1:0] rdata, data, q_dmem;
  logic [ADDR_W-1:0] address_dmem;
  state_t            dbg_state;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- syncram environment model ----------------
  logic              mem_clr = 1'b1;
  logic [DATA_W-1:0] mem  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] pipe [0:RD_LAT-1];

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
    end else if (wren) begin
      mem[address_dmem] <= data;
    end
    pipe[0] <= mem[address_dmem];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign q_dmem = pipe[RD_LAT-1];

  // ---------------- scoreboard state ----------------
  int                n_vec = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_mem [int];

  function automatic int exp_winner(logic [1:0] r, int last);
`ifdef DMEM_ARB_RR_EN
    if (r == 2'b11) return (last == 0) ? 1 : 0;
`else
    if (r == 2'b11) return 0;
`endif
    return r[0] ? 0 : 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(int n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 12'h005; req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      mem_clr = 1'b0;
      n_vec++;
      if ({gnt0, gnt1, rvalid0, rvalid1, wren, busy} !== 6'b0 || address_dmem !== '0 ||
          data !== '0 || rdata !== '0 || dbg_state !== ST_IDLE) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: gnt=%b%b rvalid=%b%b wren=%b busy=%b addr=%h data=%h rdata=%h state=%0d, required all 0 / IDLE",
                 i, gnt0, gnt1, rvalid0, rvalid1, wren, busy, address_dmem, data, rdata, dbg_state);
      end
    end
    reset = 1'b0;
    @(negedge clock);  // first edge out of reset samples req0 in IDLE
    n_vec++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_gnt: gnt0=%b gnt1=%b busy=%b, required 1 0 1", gnt0, gnt1, busy);
    end
    req0 = 1'b0;
    repeat (RD_LAT + 1) @(negedge clock);
    n_vec++;
    if (rvalid0 !== 1'b1 || rdata !== '0) begin
      n_err++;
      $display("FAIL reset_first_read: rvalid0=%b rdata=%h, required 1 00000000", rvalid0, rdata);
    end
    drain(2);
  endtask

  task automatic test_write_read();
    int wren_cnt = 0, gnt_cnt = 0, g1 = -1;
    bit early = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h010; wdata0 = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (wren) wren_cnt++;
      if (gnt0) begin
        gnt_cnt++;
        n_vec++;
        if (address_dmem !== 12'h010 || data !== 32'hDEADBEEF || wren !== 1'b1) begin
          n_err++;
          $display("FAIL wr_issue: addr=%h data=%h wren=%b, required 010 deadbeef 1", address_dmem, data, wren);
        end
        req0 = 1'b0; we0 = 1'b0;
      end
    end
    n_vec++;
    if (wren_cnt != 1 || gnt_cnt != 1) begin
      n_err++;
      $display("FAIL wr_pulses: wren cycles=%0d gnt0 pulses=%0d, required 1 1", wren_cnt, gnt_cnt);
    end
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h010;
    for (int i = 0; i < 10 && g1 < 0; i++) begin
      @(negedge clock);
      if (gnt1) g1 = cyc;
    end
    n_vec++;
    if (g1 < 0) begin
      n_err++;
      $display("FAIL rd_gnt1_timeout: gnt1 not seen in 10 cycles, required a gnt1 pulse");
    end else begin
      req1 = 1'b0;
      for (int k = 1; k <= RD_LAT; k++) begin
        @(negedge clock);
        if (rvalid0 || rvalid1) early = 1;
      end
      @(negedge clock);
      n_vec++;
      if (early || rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
        n_err++;
        $display("FAIL rd_return: early=%0d rvalid1=%b rvalid0=%b rdata=%h at gnt+%0d, required 0 1 0 deadbeef",
                 early, rvalid1, rvalid0, rdata, cyc - g1);
      end
    end
    drain(3);
  endtask

  task automatic test_back_to_back();
    int prev_g = -1, n_g = 0, n_rv = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h020;
    for (int i = 0; i < 60 && n_g < 5; i++) begin
      @(negedge clock);
      if (rvalid0) begin
        n_rv++;
        n_vec++;
        if (prev_g < 0 || cyc - prev_g != RD_LAT + 1) begin
          n_err++;
          $display("FAIL b2b_rvalid_lat: rvalid0 %0d cycles after gnt0, required %0d", cyc - prev_g, RD_LAT + 1);
        end
      end
      if (gnt0) begin
        if (prev_g >= 0) begin
          n_vec++;
          if (cyc - prev_g != RD_LAT + 2) begin
            n_err++;
            $display("FAIL b2b_gnt_spacing: %0d cycles, required %0d", cyc - prev_g, RD_LAT + 2);
          end
        end
        prev_g = cyc;
        n_g++;
      end
    end
    n_vec++;
    if (n_g != 5 || n_rv != 4) begin
      n_err++;
      $display("FAIL b2b_count: gnt0=%0d rvalid0=%0d, required 5 4", n_g, n_rv);
    end
    drain(RD_LAT + 3);
  endtask

  task automatic test_reset_mid();
    bit got = 0, stray = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (gnt0) got = 1;
    end
    req0 = 1'b0;
    @(negedge clock);  // first WAIT cycle
    reset = 1'b1;
    @(negedge clock);
    n_vec++;
    if (!got || rvalid0 !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL mid_reset: granted=%0d rvalid0=%b busy=%b state=%0d, required 1 0 0 IDLE",
               got, rvalid0, busy, dbg_state);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (rvalid0 || rvalid1 || gnt0 || gnt1) stray = 1;
    end
    n_vec++;
    if (stray) begin
      n_err++;
      $display("FAIL mid_reset_discard: activity after reset, required none");
    end
  endtask

  task automatic test_tie();
    int n_g = 0, exp_p, got_p;
    bit both = 0;
    apply_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 12'h001; addr1 = 12'h002;
    for (int i = 0; i < 80 && n_g < 6; i++) begin
      @(negedge clock);
      if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) both = 1;
      if (gnt0 || gnt1) begin
`ifdef DMEM_ARB_RR_EN
        exp_p = n_g % 2;
`else
        exp_p = 0;
`endif
        got_p = gnt1 ? 1 : 0;
        n_vec++;
        if (got_p != exp_p) begin
          n_err++;
          $display("FAIL tie_order grant#%0d: port %0d, required port %0d", n_g, got_p, exp_p);
        end
        n_g++;
      end
    end
    n_vec++;
    if (n_g != 6 || both) begin
      n_err++;
      $display("FAIL tie_progress: grants=%0d dual_pulse=%0d, required 6 0", n_g, both);
    end
    drain(RD_LAT + 3);
  endtask

  task automatic test_random();
    int          grants = 0, idle_from = 0, model_last = 1, rv_cycle = -1, rv_port = 0, w;
    bit          prev_idle = 1, exp_g, exp_rv;
    logic [1:0]  prev_req = 2'b00;
    logic        w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wd, e;
    exp_q.delete();
    ref_mem.delete();
    apply_reset();
    for (int it = 0; it < 30000 && grants < 2000; it++) begin
      // ---- observe and check this cycle ----
      exp_g = prev_idle && (prev_req != 2'b00);
      w = exp_winner(prev_req, model_last);
      w_we   = (w == 0) ? we0 : we1;
      w_addr = (w == 0) ? addr0 : addr1;
      w_wd   = (w == 0) ? wdata0 : wdata1;
      n_vec++;
      if (gnt0 !== (exp_g && w == 0) || gnt1 !== (exp_g && w == 1) || wren !== (exp_g && w_we)) begin
        n_err++;
        $display("FAIL rand_gnt cyc%0d: gnt=%b%b wren=%b, required gnt=%b%b wren=%b",
                 cyc, gnt1, gnt0, wren, exp_g && w == 1, exp_g && w == 0, exp_g && w_we);
      end
      if (exp_g) begin
        n_vec++;
        if (address_dmem !== w_addr || (w_we && data !== w_wd)) begin
          n_err++;
          $display("FAIL rand_issue cyc%0d: addr=%h data=%h, required addr=%h data=%h", cyc, address_dmem, data, w_addr, w_wd);
        end
        if (w_we) begin
          ref_mem[int'(w_addr)] = w_wd;
          idle_from = cyc + 1;
        end else begin
          exp_q.push_back(ref_mem.exists(int'(w_addr)) ? ref_mem[int'(w_addr)] : '0);
          rv_cycle = cyc + RD_LAT + 1;
          rv_port = w;
          idle_from = cyc + RD_LAT + 1;
        end
        model_last = w;
        grants++;
      end
      exp_rv = (cyc == rv_cycle);
      n_vec++;
      if (rvalid0 !== (exp_rv && rv_port == 0) || rvalid1 !== (exp_rv && rv_port == 1)) begin
        n_err++;
        $display("FAIL rand_rvalid cyc%0d: rvalid=%b%b, required %b%b", cyc, rvalid1, rvalid0,
                 exp_rv && rv_port == 1, exp_rv && rv_port == 0);
      end
      if (exp_rv && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (rdata !== e) begin
          n_err++;
          $display("FAIL rand_rdata cyc%0d: rdata=%h, required %h", cyc, rdata, e);
        end
      end
      if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) begin
        n_err++;
        $display("FAIL rand_exclusive cyc%0d: gnt=%b%b rvalid=%b%b, required not both", cyc, gnt1, gnt0, rvalid1, rvalid0);
      end
      prev_idle = (cyc >= idle_from);
      // ---- drive next cycle ----
      if (exp_g && w == 0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = ADDR_W'($urandom_range(0, 31)); wdata0 = $urandom;
      end
      if (exp_g && w == 1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = ADDR_W'($urandom_range(0, 31)); wdata1 = $urandom;
      end
      prev_req = {req1, req0};
      @(negedge clock);
    end
    n_vec++;
    if (grants < 2000) begin
      n_err++;
      $display("FAIL rand_progress: %0d accesses granted, required 2000", grants);
    end
    drain(RD_LAT + 3);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_tie();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
